// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_ctrl_pkg
//  Brief   : Shared types and encodings for the multicycle MIPS controller:
//            state enum, opcode/funct constants, ALU and mux select codes,
//            and the Moore control-word decoder used by the FSM.
//  Rev     : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_HALT    = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALUCTL_ADD = 3'b010;
   localparam logic [2:0] ALUCTL_SUB = 3'b110;
   localparam logic [2:0] ALUCTL_AND = 3'b000;
   localparam logic [2:0] ALUCTL_OR  = 3'b001;
   localparam logic [2:0] ALUCTL_SLT = 3'b111;

   localparam logic [1:0] ALUSRCB_REG   = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_SHIMM = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Moore control word. irwrite_en/pcwrite_gated only take effect together
   // with mem_ready; alu_from_funct hands alucontrol to the funct decoder.
   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       irwrite_en;
      logic       pcwrite_gated;
      logic       pcwrite;
      logic       branch;
      logic       regwrite;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       regdst;
      logic       memtoreg;
      logic       alu_from_funct;
      logic [2:0] alucontrol;
   } ctrl_t;

   function automatic ctrl_t ctrl_decode(input state_e s);
      ctrl_t c;
      c            = '0;
      c.alucontrol = ALUCTL_ADD;
      case (s)
         S_FETCH: begin
            c.mem_req       = 1'b1;
            c.irwrite_en    = 1'b1;
            c.pcwrite_gated = 1'b1;
            c.alusrcb       = ALUSRCB_FOUR;
         end
         S_DECODE: c.alusrcb = ALUSRCB_SHIMM;
         S_MEMADR, S_ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = ALUSRCB_IMM;
         end
         S_MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_req  = 1'b1;
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_EXECUTE: begin
            c.alusrca        = 1'b1;
            c.alusrcb        = ALUSRCB_REG;
            c.alu_from_funct = 1'b1;
         end
         S_ALUWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = ALUSRCB_REG;
            c.alucontrol = ALUCTL_SUB;
            c.pcsrc      = PCSRC_ALUOUT;
            c.branch     = 1'b1;
         end
         S_ADDIWB: c.regwrite = 1'b1;
         S_JUMP: begin
            c.pcsrc   = PCSRC_JUMP;
            c.pcwrite = 1'b1;
         end
         S_HALT:  c = '0;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_aludec.sv
`default_nettype none
// ============================================================================
//  Module  : mips_aludec
//  Brief   : Combinational R-type funct to ALU control decoder with a valid
//            flag for unsupported funct codes.
//  Rev     : 1.0  initial release
// ============================================================================
module mips_aludec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o,
   output logic       valid_o
);

   // Map funct to ALU operation; unknown codes fall back to add and flag invalid.
   always_comb begin
      alucontrol_o = ALUCTL_ADD;
      valid_o      = 1'b1;
      case (funct_i)
         FN_ADD:  alucontrol_o = ALUCTL_ADD;
         FN_SUB:  alucontrol_o = ALUCTL_SUB;
         FN_AND:  alucontrol_o = ALUCTL_AND;
         FN_OR:   alucontrol_o = ALUCTL_OR;
         FN_SLT:  alucontrol_o = ALUCTL_SLT;
         default: valid_o      = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mips_multicycle_ctrl
//  Brief   : Multicycle MIPS control FSM with a shared-memory req/ready
//            handshake and wait-state watchdog. Moore outputs are registered
//            from the next state; only irwrite/pcen/illegal_op and the
//            EXECUTE alucontrol combine in live inputs.
//            Optional feature macro MC_PERF_CNT_EN adds cycle_cnt/instr_cnt.
//  Rev     : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 255,
   parameter int unsigned CNT_W    = 32
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       regdst,
   output logic       memtoreg,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic       mem_err
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   localparam int unsigned WAIT_W    = 16;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   state_e            state_q, state_d;
   ctrl_t             ctrl_q;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;

   logic       w_fn_valid;
   logic [2:0] w_fn_aluctl;
   logic       w_op_legal;
   logic       w_stall;
   logic       w_done;

   mips_aludec u_aludec (
      .funct_i      (funct),
      .alucontrol_o (w_fn_aluctl),
      .valid_o      (w_fn_valid)
   );

   assign w_op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                       (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   // mem_ready only counts while a request is actually on the bus.
   assign w_stall = ctrl_q.mem_req & ~mem_ready;
   assign w_done  = ctrl_q.mem_req &  mem_ready;

   // Next-state, wait-counter and watchdog logic.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         S_FETCH:   if (w_done) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (w_done) state_d = S_MEMWB;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   if (w_done) state_d = S_FETCH;
         S_EXECUTE: state_d = w_fn_valid ? S_ALUWB : S_FETCH;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_FETCH;
      endcase
      if (w_stall) begin
         if (wait_q >= WAIT_LAST) begin
            state_d   = S_HALT;
            mem_err_d = 1'b1;
         end else begin
            wait_d = wait_q + 1'b1;
         end
      end
      if (state_d != state_q) wait_d = '0;
   end

   // State register plus control word registered from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         ctrl_q    <= '0;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_decode(state_d);
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_req    = ctrl_q.mem_req;
   assign memwrite   = ctrl_q.memwrite;
   assign irwrite    = ctrl_q.irwrite_en & mem_ready;
   assign pcen       = ctrl_q.pcwrite | (ctrl_q.pcwrite_gated & mem_ready) |
                       (ctrl_q.branch & zero);
   assign regwrite   = ctrl_q.regwrite;
   assign iord       = ctrl_q.iord;
   assign alusrca    = ctrl_q.alusrca;
   assign alusrcb    = ctrl_q.alusrcb;
   assign pcsrc      = ctrl_q.pcsrc;
   assign regdst     = ctrl_q.regdst;
   assign memtoreg   = ctrl_q.memtoreg;
   assign alucontrol = ctrl_q.alu_from_funct ? w_fn_aluctl : ctrl_q.alucontrol;
   assign illegal_op = ((state_q == S_DECODE)  && !w_op_legal) ||
                       ((state_q == S_EXECUTE) && !w_fn_valid);
   assign mem_err    = mem_err_q;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] instr_cnt_q;
   logic             w_retire;

   // An instruction retires when a completing state hands back to FETCH.
   always_comb begin
      w_retire = 1'b0;
      case (state_q)
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
         S_MEMWR: w_retire = w_done;
         default: w_retire = 1'b0;
      endcase
   end

   // Free-running performance counters, frozen in HALT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if (state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + 1'b1;
         if (w_retire)          instr_cnt_q <= instr_cnt_q + 1'b1;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`else
   // Counter width only matters when the performance counters are built.
   if (CNT_W > 0) begin : g_no_perf_cnt
   end
`endif

endmodule
`default_nettype wire
